wb_queue: RTL and testbench
===========================

# wb_queue

Writeback queue between the pipeline writeback stage and the register file write port. Buffers up to DEPTH (rd, data) writeback requests, drains the oldest one per enabled cycle onto the register file write-control lines (the 5-bit select and enable consumed by decoder_32), and forwards the newest pending value for two read addresses so readers never see stale registers while writes are queued.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- DATA_W, 32, writeback data width
- ADDR_W, 5, register address width (32 registers)

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; flushes queue
- in_valid  in  1  writeback request present
- in_ready  out  1  queue can accept (count < DEPTH)
- in_rd  in  ADDR_W  destination register
- in_data  in  DATA_W  writeback value
- drain_en  in  1  write port available this cycle
- ctrl_writeEnable  out  1  drives decoder_32 enable
- ctrl_writeReg  out  ADDR_W  drives decoder_32 select
- data_writeReg  out  DATA_W  write data to register file
- rd_addrA, rd_addrB  in  ADDR_W  read-port addresses to check
- fwd_hitA, fwd_hitB  out  1  a pending entry targets that address
- fwd_dataA, fwd_dataB  out  DATA_W  newest pending value for that address
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Storage: circular buffer of DEPTH entries {rd, data}, head/tail pointers ($clog2(DEPTH) bits, wrap modulo DEPTH), separate count register.
- Enqueue: in_valid & in_ready at rising edge -> entry written at tail, tail+1. Requests with in_rd == 0 are accepted (handshake completes) but not stored; count unchanged.
- Dequeue: ctrl_writeEnable = (count != 0) & drain_en; when high, head entry is written by register file at the same edge, head+1, count-1.
- ctrl_writeReg/data_writeReg always show head entry; when empty, both are 0.
- Simultaneous enqueue and dequeue: both happen; count unchanged. Full queue with drain: in_ready stays 0 that cycle (no same-cycle pass-through).
- Forwarding: per port, compare address against all valid entries; newest (closest to tail) matching entry wins. Address 0 never hits; fwd_data = 0 when no hit. Incoming in_data is not forwarded until stored.
- Head entry still forwards during the cycle it is being drained.

## Timing
- Reset (async assert, sync-to-clock release): count=0, head=tail=0, ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, fwd_hit*=0, fwd_data*=0, in_ready=1.
- Enqueue-to-drain latency: 1 cycle minimum (accepted at edge N, written at edge N+1 if drain_en).
- Enqueue-to-forward latency: 1 cycle (hit visible after edge N).
- in_ready, count registered-derived; ctrl_writeEnable and fwd_* combinational from stored state plus drain_en/rd_addr*.
- Throughput: one enqueue and one dequeue per cycle.
- Reset mid-operation: all pending entries discarded, no write issued during or after reset.

## Structure
- Shared package wb_pkg: DEPTH, DATA_W, ADDR_W, PTR_W = $clog2(DEPTH), CNT_W = PTR_W+1, entry struct {rd, data}.
- One sub-module: wb_fwd_match (one instance per read port): age-priority address match over the buffer, returns hit and data; combinational.
- Top holds pointers, count, storage, handshake logic.

## Test plan
- Reset then idle: count=0, in_ready=1, ctrl_writeEnable=0, fwd_hitA=0 with rd_addrA=5.
- Enqueue (rd=3, 0xDEADBEEF), drain_en=1 -> next cycle ctrl_writeEnable=1, ctrl_writeReg=3, data_writeReg=0xDEADBEEF; cycle after, count=0.
- drain_en=0, enqueue 4 entries -> in_ready=0, count=4; fifth request held; raise drain_en -> entries leave in order, one per cycle, in_ready=1 after first drain.
- Enqueue (rd=7,0x11) then (rd=7,0x22), rd_addrA=7 -> fwd_hitA=1, fwd_dataA=0x22; after both drained fwd_hitA=0.
- Enqueue rd=0 value 0x55 -> handshake completes, count stays 0, no write, rd_addrB=0 gives fwd_hitB=0.
- Assert reset with 3 entries pending mid-drain -> outputs return to reset values immediately, no further ctrl_writeEnable pulses; pointer wrap checked by 10 back-to-back enqueue/dequeue pairs preserving order.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared sizing constants and the queue entry layout for the writeback queue.
package wb_pkg;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Age-priority address match over the queue storage for one read port.
// It returns the newest pending value that targets the requested register.
module wb_fwd_match
  import wb_pkg::*;
(
  input  entry_t [DEPTH-1:0]  entries,
  input  logic   [PTR_W-1:0]  head,
  input  logic   [CNT_W-1:0]  count,
  input  logic   [ADDR_W-1:0] addr,
  output logic                hit,
  output logic   [DATA_W-1:0] data
);

  // Walk from oldest to newest so that a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count) && (addr != '0) &&
          (entries[PTR_W'(head + PTR_W'(k))].rd == addr)) begin
        hit  = 1'b1;
        data = entries[PTR_W'(head + PTR_W'(k))].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue: buffers (rd, data) writebacks ahead of the register file
// write port, drains the oldest one per enabled cycle and forwards pending values.
module wb_queue
  import wb_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drain_en,
  output logic              ctrl_writeEnable,
  output logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] rd_addrA,
  input  logic [ADDR_W-1:0] rd_addrB,
  output logic              fwd_hitA,
  output logic              fwd_hitB,
  output logic [DATA_W-1:0] fwd_dataA,
  output logic [DATA_W-1:0] fwd_dataB,
  output logic [CNT_W-1:0]  count
);

  entry_t [DEPTH-1:0] mem;
  logic   [PTR_W-1:0] head;
  logic   [PTR_W-1:0] tail;
  logic               store;
  logic               pop;
  logic               not_empty;

  // Readiness comes only from the stored count, so a full queue never passes through.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign not_empty = (count != '0);
  assign store     = in_valid & in_ready & (in_rd != '0);
  assign pop       = ctrl_writeEnable;

  assign ctrl_writeEnable = not_empty & drain_en;
  assign ctrl_writeReg    = not_empty ? mem[head].rd   : '0;
  assign data_writeReg    = not_empty ? mem[head].data : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (store) begin
        mem[tail] <= '{rd: in_rd, data: in_data};
        tail      <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  wb_fwd_match u_fwd_a (
    .entries (mem),
    .head    (head),
    .count   (count),
    .addr    (rd_addrA),
    .hit     (fwd_hitA),
    .data    (fwd_dataA)
  );

  wb_fwd_match u_fwd_b (
    .entries (mem),
    .head    (head),
    .count   (count),
    .addr    (rd_addrB),
    .hit     (fwd_hitB),
    .data    (fwd_dataB)
  );

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue; a scoreboard queue predicts drain order,
// occupancy and forwarding values.
module tb_wb_queue;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        drain_en;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  rd_addrA;
  logic [4:0]  rd_addrB;
  logic        fwd_hitA;
  logic        fwd_hitB;
  logic [31:0] fwd_dataA;
  logic [31:0] fwd_dataB;
  logic [2:0]  count;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  logic [4:0] addrA = 5'd0;
  logic [4:0] addrB = 5'd0;

  wb_queue dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_rd            (in_rd),
    .in_data          (in_data),
    .drain_en         (drain_en),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .rd_addrA         (rd_addrA),
    .rd_addrB         (rd_addrB),
    .fwd_hitA         (fwd_hitA),
    .fwd_hitB         (fwd_hitB),
    .fwd_dataA        (fwd_dataA),
    .fwd_dataB        (fwd_dataB),
    .count            (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Newest pending entry for an address wins; register 0 never forwards.
  function automatic void modelFwd(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = 32'd0;
    if (a != 5'd0) begin
      foreach (sb[i]) begin
        if (sb[i].rd == a) begin
          h = 1'b1;
          d = sb[i].data;
        end
      end
    end
  endfunction

  task automatic checkAll();
    logic        h;
    logic [31:0] d;
    logic        expWe;
    expWe = (sb.size() != 0) && drain_en;
    checkOutput("in_ready", 32'(in_ready), 32'(sb.size() < 4));
    checkOutput("count", 32'(count), 32'(sb.size()));
    checkOutput("writeEnable", 32'(ctrl_writeEnable), 32'(expWe));
    if (sb.size() != 0) begin
      checkOutput("writeReg", 32'(ctrl_writeReg), 32'(sb[0].rd));
      checkOutput("writeData", data_writeReg, sb[0].data);
    end else begin
      checkOutput("writeReg", 32'(ctrl_writeReg), 32'd0);
      checkOutput("writeData", data_writeReg, 32'd0);
    end
    modelFwd(addrA, h, d);
    checkOutput("fwd_hitA", 32'(fwd_hitA), 32'(h));
    checkOutput("fwd_dataA", fwd_dataA, d);
    modelFwd(addrB, h, d);
    checkOutput("fwd_hitB", 32'(fwd_hitB), 32'(h));
    checkOutput("fwd_dataB", fwd_dataB, d);
  endtask

  // Drive one cycle, check the settled outputs against the model, then advance.
  task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic [31:0] data,
                               input logic drain);
    logic expReady;
    logic expWe;
    in_valid = v;
    in_rd    = rd;
    in_data  = data;
    drain_en = drain;
    rd_addrA = addrA;
    rd_addrB = addrB;
    #1;
    expReady = (sb.size() < 4);
    expWe    = (sb.size() != 0) && drain;
    checkAll();
    if (expWe) void'(sb.pop_front());
    if (v && expReady && (rd != 5'd0)) sb.push_back('{rd: rd, data: data});
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_rd    = 5'd0;
    in_data  = 32'd0;
    drain_en = 1'b0;
    rd_addrA = 5'd0;
    rd_addrB = 5'd0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    #2;

    $display("[TB] reset then idle");
    addrA = 5'd5;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);

    $display("[TB] single enqueue and drain");
    applyStimulus(1'b1, 5'd3, 32'hDEADBEEF, 1'b1);
    checkOutput("first_writeReg", 32'(ctrl_writeReg), 32'd3);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);

    $display("[TB] fill, hold fifth, drain in order");
    addrA = 5'd10;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5'(8 + i), 32'h100 + 32'(i), 1'b0);
    checkOutput("full_count", 32'(count), 32'd4);
    applyStimulus(1'b1, 5'd12, 32'h104, 1'b0);
    applyStimulus(1'b1, 5'd12, 32'h104, 1'b1);
    applyStimulus(1'b1, 5'd12, 32'h104, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);

    $display("[TB] forwarding picks the newest value");
    addrA = 5'd7;
    applyStimulus(1'b1, 5'd7, 32'h11, 1'b0);
    applyStimulus(1'b1, 5'd7, 32'h22, 1'b0);
    checkOutput("fwd_newest", fwd_dataA, 32'h22);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);

    $display("[TB] register zero requests are dropped");
    addrB = 5'd0;
    applyStimulus(1'b1, 5'd0, 32'h55, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);

    $display("[TB] reset mid-drain");
    addrA = 5'd21;
    addrB = 5'd22;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5'(20 + i), 32'hA0 + 32'(i), 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    drain_en = 1'b1;
    reset    = 1'b1;
    #1;
    sb.delete();
    checkAll();
    @(posedge clock);
    #1;
    checkAll();
    #2;
    reset = 1'b0;
    #1;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);

    $display("[TB] pointer wrap with back-to-back traffic");
    addrA = 5'd4;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 5'(1 + i), $urandom, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    checkOutput("final_count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
